// File: rtl/loop_lock_pkg.sv
// rtl/loop_lock_pkg.sv - shared state type, stat width and saturating helper for loop_lock_ctrl
package loop_lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_LOCKED,
    ST_REL,
    ST_COOL
  } loop_lock_state_t;

  localparam int STAT_W = 32;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/loop_lock_timer.sv
// rtl/loop_lock_timer.sv - loadable up/down counter with terminal-count compare
module loop_lock_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] term_val_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = down_i ? count_q - WIDTH'(1) : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == term_val_i);

endmodule

// File: rtl/loop_lock_ctrl.sv
// rtl/loop_lock_ctrl.sv - I-cache loop lock handshake/window controller; LOOP_LOCK_STATS_EN adds stat counters
module loop_lock_ctrl
  import loop_lock_pkg::*;
#(
  parameter int LOCK_TIMEOUT = 1024,
  parameter int COOLDOWN     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lock_start,
  input  logic              lock_cache,
  input  logic              flush,
  output logic              ic_lock_req,
  input  logic              ic_lock_ack,
  output logic              ic_unlock_req,
  input  logic              ic_unlock_ack,
  output logic              ic_lock_en,
  output logic              busy,
  output logic              timeout_evt
`ifdef LOOP_LOCK_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_locks,
  output logic [STAT_W-1:0] stat_timeouts
`endif
);

  localparam int TW = $clog2(LOCK_TIMEOUT);
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] COOL_INIT = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;

  loop_lock_state_t state_q, state_d;
  logic             abort_q, abort_d;
  logic             tevt_q, tevt_d;

  logic [TW-1:0] to_cnt;
  logic          to_tc;
  logic [CW-1:0] cd_cnt;
  logic          cd_tc;
  logic [CW-1:0] cd_load_val;

  logic abort_now, lock_drop, timeout_hit;

  assign abort_now   = abort_q | flush | ~lock_cache;
  assign lock_drop   = flush | ~lock_cache;
  // A fresh loop push in the same cycle as terminal count restarts the window instead of timing out
  assign timeout_hit = to_tc & ~lock_start;

  loop_lock_timer #(.WIDTH(TW)) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .load_i     ((state_q != ST_LOCKED) | lock_start),
    .load_val_i ('0),
    .en_i       (1'b1),
    .down_i     (1'b0),
    .term_val_i (TO_LAST),
    .count_o    (to_cnt),
    .tc_o       (to_tc)
  );

  assign cd_load_val = ((state_q == ST_REL) && ic_unlock_ack) ? COOL_INIT : '0;

  loop_lock_timer #(.WIDTH(CW)) u_cooldown (
    .clk        (clk),
    .rst        (rst),
    .load_i     (state_q != ST_COOL),
    .load_val_i (cd_load_val),
    .en_i       (1'b1),
    .down_i     (1'b1),
    .term_val_i ('0),
    .count_o    (cd_cnt),
    .tc_o       (cd_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      abort_q <= 1'b0;
      tevt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= abort_d;
      tevt_q  <= tevt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    abort_d = 1'b0;
    tevt_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (lock_start && !flush) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ic_lock_ack) begin
          state_d = abort_now ? ST_REL : ST_LOCKED;
        end else begin
          abort_d = abort_now;
        end
      end
      ST_LOCKED: begin
        if (lock_drop) begin
          state_d = ST_REL;
        end else if (timeout_hit) begin
          state_d = ST_REL;
          tevt_d  = 1'b1;
        end
      end
      ST_REL: begin
        if (ic_unlock_ack) state_d = (COOLDOWN > 0) ? ST_COOL : ST_IDLE;
      end
      ST_COOL: begin
        if (cd_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ic_lock_req   = (state_q == ST_REQ);
    ic_unlock_req = (state_q == ST_REL);
    ic_lock_en    = (state_q == ST_LOCKED);
    busy          = (state_q != ST_IDLE);
    timeout_evt   = tevt_q;
  end

`ifdef LOOP_LOCK_STATS_EN
  logic [STAT_W-1:0] locks_q, touts_q;
  logic              enter_locked;

  assign enter_locked = (state_q == ST_REQ) && (state_d == ST_LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locks_q <= '0;
      touts_q <= '0;
    end else begin
      if (enter_locked) locks_q <= sat_inc(locks_q);
      if (tevt_d)       touts_q <= sat_inc(touts_q);
    end
  end

  assign stat_locks    = locks_q;
  assign stat_timeouts = touts_q;
`endif

endmodule

// File: tb/tb_loop_lock_ctrl.sv
// tb/tb_loop_lock_ctrl.sv - self-checking bench for loop_lock_ctrl (COOLDOWN 16 and 0 instances)
module tb_loop_lock_ctrl;

  localparam int LT = 8;

  logic clk = 1'b0;
  logic rst;
  logic lock_start, lock_cache, flush, ic_lock_ack, ic_unlock_ack;
  logic a_lreq, a_ureq, a_en, a_busy, a_tevt;
  logic b_lreq, b_ureq, b_en, b_busy, b_tevt;
  logic [4:0] outs_a, outs_b;
  int checks = 0;
  int errors = 0;

`ifdef LOOP_LOCK_STATS_EN
  logic [31:0] a_sl, a_st, b_sl, b_st;
`endif

  always #5 clk = ~clk;

  loop_lock_ctrl #(.LOCK_TIMEOUT(LT), .COOLDOWN(16)) dut_a (
    .clk           (clk),
    .rst           (rst),
    .lock_start    (lock_start),
    .lock_cache    (lock_cache),
    .flush         (flush),
    .ic_lock_req   (a_lreq),
    .ic_lock_ack   (ic_lock_ack),
    .ic_unlock_req (a_ureq),
    .ic_unlock_ack (ic_unlock_ack),
    .ic_lock_en    (a_en),
    .busy          (a_busy),
    .timeout_evt   (a_tevt)
`ifdef LOOP_LOCK_STATS_EN
    ,
    .stat_locks    (a_sl),
    .stat_timeouts (a_st)
`endif
  );

  loop_lock_ctrl #(.LOCK_TIMEOUT(LT), .COOLDOWN(0)) dut_b (
    .clk           (clk),
    .rst           (rst),
    .lock_start    (lock_start),
    .lock_cache    (lock_cache),
    .flush         (flush),
    .ic_lock_req   (b_lreq),
    .ic_lock_ack   (ic_lock_ack),
    .ic_unlock_req (b_ureq),
    .ic_unlock_ack (ic_unlock_ack),
    .ic_lock_en    (b_en),
    .busy          (b_busy),
    .timeout_evt   (b_tevt)
`ifdef LOOP_LOCK_STATS_EN
    ,
    .stat_locks    (b_sl),
    .stat_timeouts (b_st)
`endif
  );

  assign outs_a = {a_lreq, a_ureq, a_en, a_busy, a_tevt};
  assign outs_b = {b_lreq, b_ureq, b_en, b_busy, b_tevt};

  // Reference: independent flags for each phase of the lock life-cycle
  typedef struct {
    bit req_pend;
    bit lock_on;
    bit unl;
    bit abort;
    bit tevt;
    int age;
    int cool_left;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(input mdl_t m, input bit ls, input bit lc, input bit fl,
                                 input bit la, input bit ua, input int cd);
    mdl_t r = m;
    r.tevt = 1'b0;
    if (r.req_pend) begin
      r.abort = r.abort | fl | !lc;
      if (la) begin
        r.req_pend = 1'b0;
        if (r.abort) r.unl = 1'b1;
        else begin
          r.lock_on = 1'b1;
          r.age = 0;
        end
        r.abort = 1'b0;
      end
    end else if (r.lock_on) begin
      if (fl || !lc) begin
        r.lock_on = 1'b0;
        r.unl = 1'b1;
      end else if (ls) begin
        r.age = 0;
      end else if (r.age == LT - 1) begin
        r.lock_on = 1'b0;
        r.unl = 1'b1;
        r.tevt = 1'b1;
      end else begin
        r.age++;
      end
    end else if (r.unl) begin
      if (ua) begin
        r.unl = 1'b0;
        r.cool_left = cd;
      end
    end else if (r.cool_left > 0) begin
      r.cool_left--;
    end else if (ls && !fl) begin
      r.req_pend = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [4:0] mout(input mdl_t m);
    logic bz;
    bz = m.req_pend | m.lock_on | m.unl | (m.cool_left > 0);
    return {m.req_pend, m.unl, m.lock_on, bz, m.tevt};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit ls, input bit lc, input bit fl, input bit la, input bit ua);
    @(negedge clk);
    lock_start = ls;
    lock_cache = lc;
    flush = fl;
    ic_lock_ack = la;
    ic_unlock_ack = ua;
    @(posedge clk);
    #1;
    ma = mstep(ma, ls, lc, fl, la, ua, 16);
    mb = mstep(mb, ls, lc, fl, la, ua, 0);
    chk("model_a", int'(outs_a), int'(mout(ma)));
    chk("model_b", int'(outs_b), int'(mout(mb)));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((a_busy || b_busy) && n < 60) begin
      step(0, 0, 0, 1, 1);
      n++;
    end
    chk("idle_reached", int'(a_busy | b_busy), 0);
  endtask

  typedef struct {
    bit ls, lc, fl, la, ua;
    logic [4:0] ea;
    logic [4:0] eb;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[13];
    int en_cnt, tevt_cnt, en_seen, lreq_seen;

    // outputs {lock_req, unlock_req, lock_en, busy, timeout_evt}
    tbl[0]  = '{1, 1, 0, 0, 0, 5'b10010, 5'b10010};
    tbl[1]  = '{0, 1, 0, 0, 0, 5'b10010, 5'b10010};
    tbl[2]  = '{0, 1, 0, 0, 0, 5'b10010, 5'b10010};
    tbl[3]  = '{0, 1, 0, 1, 0, 5'b00110, 5'b00110};
    tbl[4]  = '{0, 1, 0, 0, 0, 5'b00110, 5'b00110};
    tbl[5]  = '{0, 1, 0, 0, 0, 5'b00110, 5'b00110};
    tbl[6]  = '{0, 0, 0, 0, 0, 5'b01010, 5'b01010};
    tbl[7]  = '{0, 0, 0, 0, 0, 5'b01010, 5'b01010};
    tbl[8]  = '{0, 0, 0, 0, 1, 5'b00010, 5'b00000};
    tbl[9]  = '{1, 0, 0, 0, 0, 5'b00010, 5'b10010};
    tbl[10] = '{0, 1, 0, 1, 0, 5'b00010, 5'b00110};
    tbl[11] = '{0, 1, 1, 0, 0, 5'b00010, 5'b01010};
    tbl[12] = '{0, 1, 0, 0, 1, 5'b00010, 5'b00000};

    ma = '{default: 0};
    mb = '{default: 0};
    rst = 1'b1;
    lock_start = 1'b0;
    lock_cache = 1'b0;
    flush = 1'b0;
    ic_lock_ack = 1'b0;
    ic_unlock_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", int'(outs_a), 0);
    chk("reset_b", int'(outs_b), 0);
`ifdef LOOP_LOCK_STATS_EN
    chk("reset_stats", int'(a_sl | a_st | b_sl | b_st), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].ls, tbl[i].lc, tbl[i].fl, tbl[i].la, tbl[i].ua);
      chk($sformatf("tbl_a[%0d]", i), int'(outs_a), int'(tbl[i].ea));
      chk($sformatf("tbl_b[%0d]", i), int'(outs_b), int'(tbl[i].eb));
    end
    wait_idle();

    // Timeout with lock_cache held: LT locked cycles then a single pulse
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    en_cnt = int'(a_en);
    tevt_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0);
      en_cnt += int'(a_en);
      tevt_cnt += int'(a_tevt);
    end
    chk("timeout_locked_cycles", en_cnt, LT);
    chk("timeout_pulses", tevt_cnt, 1);
    chk("timeout_unlock_req", int'(a_ureq), 1);
    wait_idle();

    // Flush in REQ: request held until ack, then straight to release
    step(1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    en_seen = int'(a_en);
    chk("flush_req_held", int'(a_lreq), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0);
      en_seen |= int'(a_en);
      chk("flush_req_held", int'(a_lreq), 1);
    end
    step(0, 1, 0, 1, 0);
    en_seen |= int'(a_en);
    chk("flush_to_rel", int'(outs_a), 5'b01010);
    chk("flush_no_lock_en", en_seen, 0);
    wait_idle();

    // Periodic re-arm keeps the window open; lock_start during COOL is dropped
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    tevt_cnt = 0;
    en_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(i % 4 == 3, 1, 0, 0, 0);
      tevt_cnt += int'(a_tevt);
      en_cnt += int'(a_en);
    end
    chk("rearm_no_timeout", tevt_cnt, 0);
    chk("rearm_lock_en_held", en_cnt, 40);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    lreq_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 0, 0);
      lreq_seen |= int'(a_lreq);
    end
    chk("cool_ignores_start", lreq_seen, 0);
    wait_idle();

    // Asynchronous reset while unlock request is pending
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst_unlock_req", int'(a_ureq), 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_a", int'(outs_a), 0);
    chk("rst_async_b", int'(outs_b), 0);
`ifdef LOOP_LOCK_STATS_EN
    chk("rst_stats", int'(a_sl | a_st | b_sl | b_st), 0);
`endif
    ma = '{default: 0};
    mb = '{default: 0};
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 0, 0);
    chk("post_rst_idle", int'(a_busy | b_busy), 0);

    for (int i = 0; i < 3000; i++) begin
      step($urandom % 6 == 0, $urandom % 10 != 0, $urandom % 25 == 0,
           $urandom % 3 == 0, $urandom % 3 == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
